// File: rtl/ucdp_fifo_dnsize.sv
// ucdp_fifo_dnsize: pops wide words from a show-ahead sync FIFO and
// replays each one as ratio_p narrow beats on a valid/ready stream,
// least significant slice first.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no word held; pops the FIFO head as soon as it is non-empty
// SEND  | word_r held, beat cnt_r on out_data_o, out_valid_o asserted
module ucdp_fifo_dnsize #(
    parameter int dwidth_p = 32,
    parameter int ratio_p  = 4,
    parameter int owidth_p = dwidth_p / ratio_p
) (
    input  logic                src_clk_i,
    input  logic                src_rst_an_i,
    input  logic                flush_i,
    output logic                fifo_rd_en_o,
    input  logic [dwidth_p-1:0] fifo_rd_data_i,
    input  logic                fifo_rd_empty_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [owidth_p-1:0] out_data_o,
    output logic                out_last_o
);

    localparam int cwidth_p = (ratio_p > 1) ? $clog2(ratio_p) : 1;
    localparam logic [cwidth_p-1:0] last_cnt_c = cwidth_p'(ratio_p - 1);

    if ((ratio_p < 1) || ((dwidth_p % ratio_p) != 0) || (owidth_p * ratio_p != dwidth_p)) begin : g_param_err
        $error("ucdp_fifo_dnsize: ratio_p must be >= 1 and divide dwidth_p into owidth_p slices");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state_r;
    logic [dwidth_p-1:0]   word_r;
    logic [cwidth_p-1:0]   cnt_r;
    logic                  last_beat;
    logic                  xfer;
    logic                  pop;

    assign out_valid_o  = (state_r == SEND);
    assign last_beat    = (cnt_r == last_cnt_c);
    assign xfer         = out_valid_o & out_ready_i;
    // A new word is fetched only when nothing is held or the last slice is
    // leaving this cycle, so a reload never creates a bubble.
    assign pop          = ~fifo_rd_empty_i & ~flush_i & ((state_r == IDLE) | (xfer & last_beat));
    assign fifo_rd_en_o = pop;
    assign out_last_o   = out_valid_o & last_beat;
    assign out_data_o   = owidth_p'(word_r >> (cnt_r * owidth_p));

    // Beat sequencer: flush wins over everything, then reload, then advance.
    always_ff @(posedge src_clk_i or negedge src_rst_an_i) begin
        if (!src_rst_an_i) begin
            state_r <= IDLE;
            word_r  <= '0;
            cnt_r   <= '0;
        end else if (flush_i) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else if (pop) begin
            state_r <= SEND;
            word_r  <= fifo_rd_data_i;
            cnt_r   <= '0;
        end else if (xfer) begin
            if (last_beat) begin
                state_r <= IDLE;
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ucdp_fifo_dnsize.sv
// Scoreboard bench for ucdp_fifo_dnsize: a 32/4 instance and an 8/1
// instance, each fed by a queue-based show-ahead FIFO model.
module tb_ucdp_fifo_dnsize;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        flush0, ready0, rd_en0, empty0, valid0, last0;
    logic [31:0] rdata0;
    logic [7:0]  data0;

    logic        flush1, ready1, rd_en1, empty1, valid1, last1;
    logic [7:0]  rdata1;
    logic [7:0]  data1;

    logic [31:0] q0[$];
    logic [7:0]  q1[$];
    beat_t       exp0[$];
    beat_t       exp1[$];
    int          beat_cyc[$];
    logic        beat_pop[$];
    int          b1_cyc[$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_pop0 = 0;
    int          n_pop1 = 0;
    logic        p0, p1;
    logic        prev_stall0, prev_flush0, prev_l0;
    logic [7:0]  prev_d0;

    always #5 clk = ~clk;

    ucdp_fifo_dnsize #(.dwidth_p(32), .ratio_p(4)) u_dut (
        .src_clk_i       (clk),
        .src_rst_an_i    (rst_n),
        .flush_i         (flush0),
        .fifo_rd_en_o    (rd_en0),
        .fifo_rd_data_i  (rdata0),
        .fifo_rd_empty_i (empty0),
        .out_valid_o     (valid0),
        .out_ready_i     (ready0),
        .out_data_o      (data0),
        .out_last_o      (last0)
    );

    ucdp_fifo_dnsize #(.dwidth_p(8), .ratio_p(1)) u_dut1 (
        .src_clk_i       (clk),
        .src_rst_an_i    (rst_n),
        .flush_i         (flush1),
        .fifo_rd_en_o    (rd_en1),
        .fifo_rd_data_i  (rdata1),
        .fifo_rd_empty_i (empty1),
        .out_valid_o     (valid1),
        .out_ready_i     (ready1),
        .out_data_o      (data1),
        .out_last_o      (last1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic void refresh();
        empty0 = (q0.size() == 0);
        rdata0 = empty0 ? 32'h0 : q0[0];
        empty1 = (q1.size() == 0);
        rdata1 = empty1 ? 8'h0 : q1[0];
    endfunction

    function automatic void push_word0(input logic [31:0] w);
        q0.push_back(w);
        for (int i = 0; i < 4; i++) exp0.push_back('{d: w[i*8 +: 8], l: (i == 3)});
        refresh();
    endfunction

    function automatic void push_word1(input logic [7:0] w);
        q1.push_back(w);
        exp1.push_back('{d: w, l: 1'b1});
        refresh();
    endfunction

    task automatic monitor();
        beat_t b;
        logic  done;
        if (!rst_n) begin
            prev_stall0 = 1'b0;
            prev_flush0 = 1'b0;
            return;
        end
        if (rd_en0) chk("pop_while_empty0", empty0, 1'b0);
        if (rd_en1) chk("pop_while_empty1", empty1, 1'b0);
        if (prev_stall0 && !prev_flush0) begin
            chk("stall_valid", valid0, 1'b1);
            chk("stall_data", data0, prev_d0);
            chk("stall_last", last0, prev_l0);
        end
        if (valid0 && !ready0) chk("stall_pop", rd_en0, 1'b0);
        if (!valid0) chk("idle_last0", last0, 1'b0);
        if (flush0) begin
            if (valid0) begin
                done = 1'b0;
                while (!done && exp0.size() > 0) begin
                    b = exp0.pop_front();
                    done = b.l;
                end
            end
        end else if (valid0 && ready0) begin
            if (exp0.size() == 0) begin
                chk("unexpected_beat0", data0, 8'h0);
                chk("unexpected_beat0_present", 1'b1, 1'b0);
            end else begin
                b = exp0.pop_front();
                chk("beat_data0", data0, b.d);
                chk("beat_last0", last0, b.l);
            end
            beat_cyc.push_back(cyc);
            beat_pop.push_back(rd_en0);
        end
        if (!valid1) chk("idle_last1", last1, 1'b0);
        if (valid1 && ready1) begin
            if (exp1.size() == 0) begin
                chk("unexpected_beat1_present", 1'b1, 1'b0);
            end else begin
                b = exp1.pop_front();
                chk("beat_data1", data1, b.d);
                chk("beat_last1", last1, b.l);
            end
            b1_cyc.push_back(cyc);
        end
        prev_stall0 = valid0 && !ready0;
        prev_flush0 = flush0;
        prev_d0     = data0;
        prev_l0     = last0;
    endtask

    // One clock: check at the falling edge, let the FIFO model pop just after the rising edge.
    task automatic tick();
        @(negedge clk);
        monitor();
        p0 = rd_en0;
        p1 = rd_en1;
        @(posedge clk);
        cyc++;
        #1;
        if (p0 && rst_n && q0.size() > 0) begin
            void'(q0.pop_front());
            n_pop0++;
        end
        if (p1 && rst_n && q1.size() > 0) begin
            void'(q1.pop_front());
            n_pop1++;
        end
        refresh();
    endtask

    task automatic drain(input int max_cyc, input bit rand_ready);
        for (int i = 0; i < max_cyc; i++) begin
            if (exp0.size() == 0 && exp1.size() == 0 && !valid0 && !valid1) break;
            if (rand_ready) ready0 = 1'($urandom_range(0, 1));
            tick();
        end
        ready0 = 1'b1;
        chk("drain_timeout", exp0.size() + exp1.size(), 0);
    endtask

    initial begin
        int pc;
        int np;

        rst_n  = 1'b0;
        flush0 = 1'b0;
        ready0 = 1'b1;
        flush1 = 1'b0;
        ready1 = 1'b1;
        prev_stall0 = 1'b0;
        prev_flush0 = 1'b0;
        prev_d0 = 8'h0;
        prev_l0 = 1'b0;
        refresh();
        #2;

        // reset with FIFO empty
        chk("rst_valid0", valid0, 1'b0);
        chk("rst_data0", data0, 8'h00);
        chk("rst_last0", last0, 1'b0);
        chk("rst_rd_en0", rd_en0, 1'b0);
        chk("rst_valid1", valid1, 1'b0);
        chk("rst_rd_en1", rd_en1, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // single word, ready held high
        beat_cyc.delete();
        beat_pop.delete();
        np = n_pop0;
        pc = cyc;
        push_word0(32'hDDCCBBAA);
        drain(20, 1'b0);
        chk("s2_pops", n_pop0 - np, 1);
        chk("s2_nbeats", beat_cyc.size(), 4);
        chk("s2_latency", beat_cyc[0] - pc, 1);
        chk("s2_span", beat_cyc[3] - beat_cyc[0], 3);
        chk("s2_idle", valid0, 1'b0);

        // two words back to back, no bubble at the reload
        beat_cyc.delete();
        beat_pop.delete();
        np = n_pop0;
        push_word0(32'h03020100);
        push_word0(32'h07060504);
        drain(30, 1'b0);
        chk("s3_pops", n_pop0 - np, 2);
        chk("s3_nbeats", beat_cyc.size(), 8);
        chk("s3_span", beat_cyc[7] - beat_cyc[0], 7);
        chk("s3_pop_at_beat3", beat_pop[3], 1'b1);
        chk("s3_nopop_at_beat7", beat_pop[7], 1'b0);

        // backpressure while showing 0xBB
        np = n_pop0;
        push_word0(32'hDDCCBBAA);
        tick();
        tick();
        ready0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s4_valid", valid0, 1'b1);
            chk("s4_data", data0, 8'hBB);
            chk("s4_nopop", rd_en0, 1'b0);
        end
        ready0 = 1'b1;
        drain(20, 1'b0);
        chk("s4_pops", n_pop0 - np, 1);

        // flush while showing 0xCC with another word waiting
        np = n_pop0;
        push_word0(32'hDDCCBBAA);
        push_word0(32'h44332211);
        tick();
        tick();
        tick();
        chk("s5_showing_cc", data0, 8'hCC);
        flush0 = 1'b0;
        ready0 = 1'b0;
        flush0 = 1'b1;
        #1;
        chk("s5_flush_nopop", rd_en0, 1'b0);
        tick();
        flush0 = 1'b0;
        ready0 = 1'b1;
        #1;
        chk("s5_idle_valid", valid0, 1'b0);
        chk("s5_next_pop", rd_en0, 1'b1);
        drain(20, 1'b0);
        chk("s5_pops", n_pop0 - np, 2);

        // random words under random backpressure
        np = n_pop0;
        for (int i = 0; i < 5; i++) push_word0($urandom);
        drain(300, 1'b1);
        drain(20, 1'b0);
        chk("s7_pops", n_pop0 - np, 5);

        // ratio 1: every beat last, back-to-back pops
        b1_cyc.delete();
        np = n_pop1;
        push_word1(8'h11);
        push_word1(8'h22);
        drain(20, 1'b0);
        chk("s6_pops", n_pop1 - np, 2);
        chk("s6_nbeats", b1_cyc.size(), 2);
        chk("s6_span", b1_cyc[1] - b1_cyc[0], 1);

        // reset in the middle of a stream
        push_word1(8'h33);
        push_word1(8'h44);
        push_word1(8'h55);
        tick();
        chk("s6_pre_rst_valid", valid1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_valid", valid1, 1'b0);
        chk("s6_rst_last", last1, 1'b0);
        chk("s6_rst_data", data1, 8'h00);
        q0.delete();
        q1.delete();
        exp0.delete();
        exp1.delete();
        refresh();
        #1;
        chk("s6_rst_rd_en", rd_en1, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("s6_post_rst_valid", valid1, 1'b0);
        b1_cyc.delete();
        push_word1(8'h66);
        drain(20, 1'b0);
        chk("s6_resume_beats", b1_cyc.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
